gate_sweep_ctrl: RTL and testbench
==================================

Name: gate_sweep_ctrl

Overview:
Sequencer that exhaustively sweeps all 2^N_IN input vectors through a small combinational gate network, such as the 3-input gates circuit. For each vector it drives the inputs, waits a settle interval, and samples the single DUT output. It compares that output against a parameterised truth table and reports pass/fail, a mismatch count and the first failing vector. It sits between a start/done host handshake and the combinational DUT, and serves as the on-chip self-check for gate-level blocks.

Parameters:
N_IN, 3, number of DUT inputs; sweep covers vectors 0 .. 2^N_IN-1.
SETTLE, 2, extra cycles each vector is held before sampling (legal range 0..15).
EXPECT, 8'b1110_1000, expected truth table, width 2^N_IN; bit v is the expected output for vector v. The default is 3-input majority.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a sweep; sampled only in IDLE or DONE.
abort  input  1  terminate a running sweep; higher priority than all other events except reset.
vec_out  output  N_IN  input vector driven to the DUT; vec_out[N_IN-1] is the first DUT input (x).
dut_out  input  1  DUT output under test.
busy  output  1  high while the sweep runs.
done  output  1  high in DONE; held until the next accepted start or abort.
pass  output  1  valid when done=1; 1 iff err_cnt==0.
err_cnt  output  N_IN+1  number of mismatching vectors, saturates at 2^N_IN.
first_fail  output  N_IN  lowest-numbered failing vector; valid when first_fail_vld=1.
first_fail_vld  output  1  at least one mismatch recorded in the current or last sweep.

Behaviour:
- Reset (async assert, synchronous deassert into the clk domain): state=IDLE; vec_out, err_cnt and first_fail all 0; busy, done, pass and first_fail_vld all 0.
- States:
  - IDLE: start=1 -> RUN. On the same edge: vec_out=0, settle counter=0, err_cnt/first_fail/first_fail_vld cleared, busy=1.
  - RUN: settle counter increments each cycle while vec_out is held.
    - When counter==SETTLE, dut_out is sampled on that clock edge and compared with EXPECT[vec_out].
    - Mismatch: err_cnt+1. If first_fail_vld=0, first_fail=vec_out and first_fail_vld=1.
    - Same edge, if vec_out==2^N_IN-1 -> DONE; otherwise vec_out+1 and counter=0.
  - DONE: busy=0, done=1, pass=(err_cnt==0). vec_out holds the last vector. start=1 -> RUN, with identical clearing as from IDLE and done=0 on that edge.
- Timing:
  - Each vector occupies exactly SETTLE+1 cycles. With SETTLE=0 each vector is sampled in the same cycle it is driven.
  - busy rises on the edge that accepts start. Exactly 2^N_IN*(SETTLE+1) cycles later, busy=0 and done=1.
- Abort:
  - In RUN: -> IDLE next edge; busy=0, done=0, vec_out=0. err_cnt/first_fail/first_fail_vld retain partial results.
  - In DONE: -> IDLE; done clears.
  - In IDLE: no effect.
  - abort and start in the same cycle: abort wins and start is ignored.
- start while in RUN is ignored, with no restart.
- The final-vector sample and the transition to DONE happen on the same edge. pass reflects the final vector's result in the first DONE cycle.
- err_cnt saturates at 2^N_IN and never wraps.
- vec_out wraps to 0 only via a new start or abort, never by incrementing past 2^N_IN-1.
- Reset asserted mid-sweep: immediate return to reset values, with no partial results retained.
- dut_out is ignored outside the sample cycle.

Test Plan:
- Correct majority model, N_IN=3, SETTLE=2, one-cycle start pulse -> vec_out steps 0..7, 3 cycles each; done=1 exactly 24 cycles after start is accepted; pass=1, err_cnt=0, first_fail_vld=0.
- Model inverted only on vector 5 -> done with pass=0, err_cnt=1, first_fail=5, first_fail_vld=1.
- Model stuck-at-0 -> err_cnt=4, first_fail=3. Then restart from DONE with the correct model -> err_cnt=0, first_fail_vld=0, pass=1.
- abort in the first cycle of vector 4 -> next edge state IDLE, busy=0, done=0, vec_out=0, err_cnt unchanged. start and abort in the same cycle from IDLE -> stays IDLE.
- start pulsed again while busy at vector 2 -> no restart; completion stays 24 cycles after the original start. With SETTLE=0, the sweep completes in 8 cycles.
- rst_n pulled low asynchronously at vector 6 (mid-cycle, no clk edge) -> all outputs 0 immediately. After release, start runs a full 24-cycle sweep.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweep of a small combinational block, with a pass/fail summary.
// Latency: 2^N_IN*(SETTLE+1) cycles from the accepted start to done.
// Backpressure: none; start is ignored while busy, and abort always wins.
module gate_sweep_ctrl #(
    parameter int                       N_IN   = 3,
    parameter int                       SETTLE = 2,
    parameter logic [(1 << N_IN)-1:0]   EXPECT = 8'b1110_1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld
);

    localparam logic [N_IN-1:0] VEC_MAX  = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(1 << N_IN);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [N_IN-1:0] vec_nxt;
    logic [N_IN:0]   err_nxt;
    logic [N_IN-1:0] ff_nxt;
    logic            ffv_nxt;
    logic            mismatch;

    assign mismatch = (dut_out != EXPECT[vec_out]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            vec_out        <= '0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            vec_out        <= vec_nxt;
            err_cnt        <= err_nxt;
            first_fail     <= ff_nxt;
            first_fail_vld <= ffv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vec_nxt   = vec_out;
        err_nxt   = err_cnt;
        ff_nxt    = first_fail;
        ffv_nxt   = first_fail_vld;
        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    vec_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (start) begin
                    state_nxt = RUN;
                    vec_nxt   = '0;
                    cnt_nxt   = '0;
                    err_nxt   = '0;
                    ff_nxt    = '0;
                    ffv_nxt   = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    // partial error results are kept for post-mortem
                    state_nxt = IDLE;
                    vec_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (cnt == SETTLE_C) begin
                    if (mismatch) begin
                        if (err_cnt != ERR_MAX) err_nxt = err_cnt + ERR_ONE;
                        if (!first_fail_vld) begin
                            ff_nxt  = vec_out;
                            ffv_nxt = 1'b1;
                        end
                    end
                    if (vec_out == VEC_MAX) begin
                        state_nxt = DONE;
                    end else begin
                        vec_nxt = vec_out + VEC_ONE;
                        cnt_nxt = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                vec_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic [2:0] vec_out, first_fail;
    logic       dut_out, busy, done, pass, first_fail_vld;
    logic [3:0] err_cnt;

    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [2:0] vec1, ff1;
    logic       dut1, busy1, done1, pass1, ffv1;
    logic [3:0] err1;

    int mode = 0;  // 0: majority, 1: majority inverted on vector 5, 2: stuck-at-0
    int checks = 0, failures = 0;

    typedef struct {
        logic       pass;
        logic [3:0] err;
        logic [2:0] ff;
        logic       ffv;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0: dut_out = maj(vec_out);
            1: dut_out = maj(vec_out) ^ (vec_out == 3'd5);
            default: dut_out = 1'b0;
        endcase
    end
    assign dut1 = maj(vec1);

    gate_sweep_ctrl #(.N_IN(3), .SETTLE(2), .EXPECT(8'b1110_1000)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vec_out(vec_out), .dut_out(dut_out), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .first_fail(first_fail),
        .first_fail_vld(first_fail_vld)
    );

    gate_sweep_ctrl #(.N_IN(3), .SETTLE(0), .EXPECT(8'b1110_1000)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .vec_out(vec1), .dut_out(dut1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1), .first_fail(ff1),
        .first_fail_vld(ffv1)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: tracks cycles since busy rose, checks vector stepping, and
    // scores each completed sweep against the queued expectation.
    int   k = 0;
    logic busy_q = 1'b0, done_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy && !busy_q) k = 0;
        else k++;
        if (busy && (k % 3 == 0) && k < 24) chk("vec_step", int'(vec_out), k / 3);
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("latency", k, 24);
                chk("pass", int'(pass), int'(e.pass));
                chk("err_cnt", int'(err_cnt), int'(e.err));
                chk("first_fail_vld", int'(first_fail_vld), int'(e.ffv));
                if (e.ffv) chk("first_fail", int'(first_fail), int'(e.ff));
            end
        end
        busy_q = busy;
        done_q = done;
    end

    task automatic push(input logic p, input int e, input int f, input logic v);
        exp_t x;
        x.pass = p; x.err = 4'(e); x.ff = 3'(f); x.ffv = v;
        sb.push_back(x);
    endtask

    task automatic start_sweep();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", int'(done), 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_vec"}, int'(vec_out), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_pass"}, int'(pass), 0);
        chk({nm, "_err"}, int'(err_cnt), 0);
        chk({nm, "_ff"}, int'(first_fail), 0);
        chk({nm, "_ffv"}, int'(first_fail_vld), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // correct model
        mode = 0; push(1'b1, 0, 0, 1'b0);
        start_sweep(); wait_done(40);

        // wrong only on vector 5
        mode = 1; push(1'b0, 1, 5, 1'b1);
        start_sweep(); wait_done(40);

        // stuck-at-0 fails 3,5,6,7; then restart clean from DONE
        mode = 2; push(1'b0, 4, 3, 1'b1);
        start_sweep(); wait_done(40);
        mode = 0; push(1'b1, 0, 0, 1'b0);
        start_sweep(); wait_done(40);

        // abort in first cycle of vector 4 (stuck model: one error so far at 3)
        mode = 2;
        start_sweep();
        repeat (12) @(negedge clk);
        chk("pre_abort_vec", int'(vec_out), 4);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_vec", int'(vec_out), 0);
        chk("abort_err", int'(err_cnt), 1);
        chk("abort_ff", int'(first_fail), 3);
        chk("abort_ffv", int'(first_fail_vld), 1);

        // start and abort together in IDLE
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        chk("sa_busy", int'(busy), 0);
        chk("sa_done", int'(done), 0);
        @(negedge clk);
        chk("sa_busy2", int'(busy), 0);

        // start again while busy at vector 2: ignored
        mode = 0; push(1'b1, 0, 0, 1'b0);
        start_sweep();
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(40);

        // SETTLE=0 instance: 8 cycles
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s0_latency", n, 8);
        chk("s0_pass", int'(pass1), 1);
        chk("s0_err", int'(err1), 0);

        // async reset mid-sweep at vector 6 (two errors recorded by then)
        mode = 2;
        start_sweep();
        repeat (18) @(negedge clk);
        chk("pre_rst_vec", int'(vec_out), 6);
        chk("pre_rst_err", int'(err_cnt), 2);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk) rst_n = 1'b1;
        mode = 0; push(1'b1, 0, 0, 1'b0);
        start_sweep(); wait_done(40);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
